proc_control: RTL and testbench

PROC_CONTROL -- requirements
Module: proc_control

---
 rtl/proc_control.sv | 138 +++++++++++++
 tb/tb_proc_control.sv | 110 +++++++++++
 2 files changed

// File: rtl/proc_control.sv
// Sequencing controller for a small bus-based processor: fetch in T0, execute in T1..T3.
// Optional macro PROC_CTRL_MVNZ_EN enables the conditional move (opcode 100, uses GNZ).
module proc_control (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [8:0]  IR,
  input  logic        GNZ,
  output logic        IRin,
  output logic [7:0]  Rout,
  output logic        Gout,
  output logic        DINout,
  output logic [7:0]  Rin,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        Done,
  output logic [15:0] ICount
);

  // state | meaning
  // T0    | idle / fetch: IR loads from DIN while Run is high
  // T1    | execute step 1 (mv, mvi, mvnz finish here; add/sub load A)
  // T2    | add/sub: operand Ry through the ALU into G
  // T3    | add/sub: G written back to Rx
  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  state_t      state, state_nxt;
  logic [15:0] icount;
  logic [2:0]  opcode, rx, ry;

  logic        irin_c, gout_c, dinout_c, ain_c, gin_c, addsub_c, done_c;
  logic [7:0]  rout_c, rin_c;

  assign opcode = IR[8:6];
  assign rx     = IR[5:3];
  assign ry     = IR[2:0];

  // R0 sits in the MSB of the select buses
  function automatic logic [7:0] reg_sel(input logic [2:0] r);
    return 8'b1000_0000 >> r;
  endfunction

`ifndef PROC_CTRL_MVNZ_EN
  logic unused_gnz;
  assign unused_gnz = GNZ;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= T0;
      icount <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (Done) icount <= icount + 16'h0001;
    end
  end

  always_comb begin
    state_nxt = T0;
    irin_c    = 1'b0;
    rout_c    = 8'h00;
    gout_c    = 1'b0;
    dinout_c  = 1'b0;
    rin_c     = 8'h00;
    ain_c     = 1'b0;
    gin_c     = 1'b0;
    addsub_c  = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      T0: begin
        irin_c    = Run;
        state_nxt = Run ? T1 : T0;
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            rout_c = reg_sel(ry);
            rin_c  = reg_sel(rx);
            done_c = 1'b1;
          end
          OP_MVI: begin
            dinout_c = 1'b1;
            rin_c    = reg_sel(rx);
            done_c   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rout_c    = reg_sel(rx);
            ain_c     = 1'b1;
            state_nxt = T2;
          end
`ifdef PROC_CTRL_MVNZ_EN
          OP_MVNZ: begin
            if (GNZ) begin
              rout_c = reg_sel(ry);
              rin_c  = reg_sel(rx);
            end
            done_c = 1'b1;
          end
`endif
          default: done_c = 1'b1;
        endcase
      end
      T2: begin
        rout_c    = reg_sel(ry);
        gin_c     = 1'b1;
        addsub_c  = (opcode == OP_SUB);
        state_nxt = T3;
      end
      T3: begin
        gout_c   = 1'b1;
        rin_c    = reg_sel(rx);
        addsub_c = (opcode == OP_SUB);
        done_c   = 1'b1;
      end
      default: state_nxt = T0;
    endcase
  end

  // Reset must silence everything at once, including IRin which follows Run
  assign IRin   = irin_c   & ~Reset;
  assign Rout   = rout_c   & {8{~Reset}};
  assign Gout   = gout_c   & ~Reset;
  assign DINout = dinout_c & ~Reset;
  assign Rin    = rin_c    & {8{~Reset}};
  assign Ain    = ain_c    & ~Reset;
  assign Gin    = gin_c    & ~Reset;
  assign AddSub = addsub_c & ~Reset;
  assign Done   = done_c   & ~Reset;
  assign ICount = icount;

endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control: stimulus pushes per-cycle expectations, a monitor checks them.
module tb_proc_control;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run   = 1'b0;
  logic [8:0]  IR    = 9'h000;
  logic        GNZ   = 1'b0;
  logic        IRin, Gout, DINout, Ain, Gin, AddSub, Done;
  logic [7:0]  Rout, Rin;
  logic [15:0] ICount;

  proc_control dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .GNZ(GNZ),
    .IRin(IRin), .Rout(Rout), .Gout(Gout), .DINout(DINout), .Rin(Rin),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .Done(Done), .ICount(ICount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [38:0] vec;  // {IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done, ICount}
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [38:0] act;
      e   = exp_q.pop_front();
      act = {IRin, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done, ICount};
      total++;
      if (act !== e.vec) begin
        bad++;
        $display("FAIL %s: got IRin=%b Rout=%b Gout=%b DINout=%b Rin=%b Ain=%b Gin=%b AddSub=%b Done=%b ICount=%h, want %b %b %b %b %b %b %b %b %b %h",
                 e.name, act[38], act[37:30], act[29], act[28], act[27:20], act[19], act[18], act[17], act[16], act[15:0],
                 e.vec[38], e.vec[37:30], e.vec[29], e.vec[28], e.vec[27:20], e.vec[19], e.vec[18], e.vec[17], e.vec[16], e.vec[15:0]);
      end
    end
  end

  // Apply one cycle of inputs and queue what the outputs must be in that cycle.
  task automatic step(input string name, input logic rst, input logic run, input logic [8:0] ir, input logic gnz,
                      input logic e_irin, input logic [7:0] e_rout, input logic e_gout, input logic e_din,
                      input logic [7:0] e_rin, input logic e_ain, input logic e_gin, input logic e_as,
                      input logic e_done, input logic [15:0] e_ic);
    exp_t e;
    Reset = rst; Run = run; IR = ir; GNZ = gnz;
    e.name = name;
    e.vec  = {e_irin, e_rout, e_gout, e_din, e_rin, e_ain, e_gin, e_as, e_done, e_ic};
    exp_q.push_back(e);
    @(posedge Clock); #1;
  endtask

  initial begin
    @(posedge Clock); #1;
    //           name          rst run IR            gnz IRin Rout   Gout DIN Rin    Ain Gin AS Done ICount
    step("reset_run_hi",  1, 1, 9'b000_000_000, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd0);
    step("mvi_t0",        0, 1, 9'b001_011_000, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd0);
    step("mvi_t1",        0, 0, 9'b001_011_000, 0, 0, 8'h00, 0, 1, 8'h10, 0, 0, 0, 1, 16'd0);
    step("mvi_idle",      0, 0, 9'b001_011_000, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd1);
    step("sub_t0",        0, 1, 9'b011_001_010, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd1);
    step("sub_t1",        0, 1, 9'b011_001_010, 0, 0, 8'h40, 0, 0, 8'h00, 1, 0, 0, 0, 16'd1);
    step("sub_t2",        0, 1, 9'b011_001_010, 0, 0, 8'h20, 0, 0, 8'h00, 0, 1, 1, 0, 16'd1);
    step("sub_t3",        0, 0, 9'b011_001_010, 0, 0, 8'h00, 1, 0, 8'h40, 0, 0, 1, 1, 16'd1);
    step("add_t0",        0, 1, 9'b010_111_000, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd2);
    step("add_t1",        0, 0, 9'b010_111_000, 0, 0, 8'h01, 0, 0, 8'h00, 1, 0, 0, 0, 16'd2);
    step("add_t2",        0, 0, 9'b010_111_000, 0, 0, 8'h80, 0, 0, 8'h00, 0, 1, 0, 0, 16'd2);
    step("add_t3",        0, 0, 9'b010_111_000, 0, 0, 8'h00, 1, 0, 8'h01, 0, 0, 0, 1, 16'd2);
    step("b2b_c1",        0, 1, 9'b000_010_010, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd3);
    step("b2b_c2_self",   0, 1, 9'b000_010_010, 0, 0, 8'h20, 0, 0, 8'h20, 0, 0, 0, 1, 16'd3);
    step("b2b_c3",        0, 1, 9'b000_000_101, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd4);
    step("b2b_c4",        0, 1, 9'b000_000_101, 0, 0, 8'h04, 0, 0, 8'h80, 0, 0, 0, 1, 16'd4);
    step("b2b_c5",        0, 1, 9'b000_110_001, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd5);
    step("b2b_c6",        0, 1, 9'b000_110_001, 0, 0, 8'h40, 0, 0, 8'h02, 0, 0, 0, 1, 16'd5);
    step("b2b_c7",        0, 1, 9'b111_000_000, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd6);
    step("unlisted_t1",   0, 0, 9'b111_000_000, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 16'd6);
    step("unlisted_idle", 0, 0, 9'b111_000_000, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd7);
    step("op100_t0_gnz1", 0, 1, 9'b100_000_111, 1, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd7);
`ifdef PROC_CTRL_MVNZ_EN
    step("mvnz_gnz1",     0, 1, 9'b100_000_111, 1, 0, 8'h01, 0, 0, 8'h80, 0, 0, 0, 1, 16'd7);
`else
    step("op100_gnz1",    0, 1, 9'b100_000_111, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 16'd7);
`endif
    step("op100_t0_gnz0", 0, 1, 9'b100_000_111, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd8);
    step("op100_gnz0",    0, 0, 9'b100_000_111, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 16'd8);
    step("rst_add_t0",    0, 1, 9'b010_001_001, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd9);
    step("rst_add_t1",    0, 0, 9'b010_001_001, 0, 0, 8'h40, 0, 0, 8'h00, 1, 0, 0, 0, 16'd9);
    step("rst_in_t2",     1, 1, 9'b010_001_001, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd0);
    step("after_rst",     0, 0, 9'b010_001_001, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'd0);
    // Preload the counter to its top value instead of spending 65535 instructions on it.
    force dut.icount = 16'hFFFF;
    #1;
    release dut.icount;
    step("wrap_t0",       0, 1, 9'b000_001_000, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'hFFFF);
    step("wrap_t1",       0, 0, 9'b000_001_000, 0, 0, 8'h80, 0, 0, 8'h40, 0, 0, 0, 1, 16'hFFFF);
    step("wrap_after",    0, 0, 9'b000_001_000, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clock);
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
